hcsr04_emulador: RTL and testbench
==================================

// Module: hcsr04_emulador
// PURPOSE
//   Responder side of the HC-SR04 ultrasonic sensor interface: emulates the sensor for bench and board tests.
//   Accepts a trigger pulse from the measurement core (trena) and returns an echo pulse after a fixed delay.
//   Echo width is proportional to a programmed distance in cm.
//   Replaces the physical sensor so measurement units can be checked against exact, repeatable echo widths.
// PARAMETERS
//   CICLOS_POR_US  50      clock cycles per microsecond (50 MHz clock)
//   TRIG_MIN_US    10      minimum synchronized trigger high time for a valid request, us
//   ATRASO_US      400     delay from trigger falling edge to echo rising edge, us
//   CICLOS_POR_CM  2941    echo high cycles per cm (58.82 us/cm at 50 MHz)
//   DIST_MIN_CM    2       distances below this are clamped up to it
//   DIST_MAX_CM    400     distances above this produce a timeout echo
//   TIMEOUT_US     38000   echo width for out-of-range distance, us
//   ESPERA_US      100     hold-off after echo falls before a new trigger is accepted, us
// PORTS
//   clock      in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high reset
//   trigger    in   1  trigger from measurement core, asynchronous to internal timing
//   distancia  in   9  emulated distance in cm (0..511), sampled at the accepted trigger falling edge
//   echo       out  1  emulated echo pulse, registered
//   ocupado    out  1  high from an accepted trigger falling edge until hold-off ends
//   db_estado  out  4  current FSM state code, for the hex display
// BEHAVIOUR
//   - Reset state: echo=0, ocupado=0, db_estado=0 (INICIAL), all counters 0.
//     Reset has priority over everything, including mid-operation: echo drops on the next edge and the FSM returns to INICIAL.
//   - trigger passes through a 2-FF synchronizer (trig_s). All timing below refers to trig_s.
//   - FSM states (db_estado code):
//     INICIAL(0): wait for trig_s=1; then go to MEDE_TRIG and clear the width counter.
//     MEDE_TRIG(1): count cycles while trig_s=1; the counter saturates at TRIG_MIN_US*CICLOS_POR_US.
//       On trig_s falling edge:
//         - counter < TRIG_MIN_US*CICLOS_POR_US -> INICIAL; the pulse is ignored and nothing is emitted.
//         - otherwise -> ATRASO; latch distancia into dist_reg; ocupado=1.
//     ATRASO(2): wait exactly ATRASO_US*CICLOS_POR_US cycles, then go to ECHO.
//       echo's first high cycle is ATRASO_US*CICLOS_POR_US cycles after the cycle that saw trig_s fall.
//     ECHO(3): echo=1 for exactly W cycles, then go to ESPERA. W is:
//       - DIST_MIN_CM*CICLOS_POR_CM if dist_reg < DIST_MIN_CM
//       - TIMEOUT_US*CICLOS_POR_US if dist_reg > DIST_MAX_CM
//       - dist_reg*CICLOS_POR_CM otherwise
//       W is generated with nested counters: an inner counter runs 0..CICLOS_POR_CM-1 and an outer counter decrements cm.
//       No multiplier; counter widths are sized from the parameters with $clog2.
//     ESPERA(4): echo=0; hold for ESPERA_US*CICLOS_POR_US cycles; ocupado=0 when leaving; go to INICIAL.
//       If trig_s is still high on entry to INICIAL, no request is accepted until trig_s has gone low and then high again.
//   - Trigger activity in ATRASO, ECHO and ESPERA is ignored; it neither restarts nor extends the echo.
//   - distancia changes after the latch do not affect the current echo.
//   - Each accepted trigger yields exactly one echo pulse.
// TESTING
//   1. Reset 2 us; check echo=0, ocupado=0, db_estado=0.
//   2. distancia=100, trigger high 10 us -> echo rises 400 us after trigger falls (+2-cycle sync).
//      Echo width = 294100 cycles (5882 us).
//   3. distancia=74, 10 us trigger -> echo width 217634 cycles (~4352.7 us).
//      Measurement core must read 74 cm.
//   4. Trigger high 5 us (250 cycles) -> no echo, ocupado stays 0, FSM back in INICIAL.
//   5. distancia=450 -> echo width 1_900_000 cycles (38 ms timeout).
//      distancia=0 -> echo width 5882 cycles (2 cm).
//   6. Second 10 us trigger issued mid-ECHO -> ignored, single echo of the original width.
//      Separately, reset asserted mid-ECHO -> echo=0 on the next edge, db_estado=0.

Source files
------------

// File: rtl/hcsr04_emulador.sv
// HC-SR04 ultrasonic sensor emulator: answers a qualified trigger pulse with an
// echo whose width encodes a programmed distance, for bench and board testing.
module hcsr04_emulador #(
  parameter int CICLOS_POR_US = 50,
  parameter int TRIG_MIN_US   = 10,
  parameter int ATRASO_US     = 400,
  parameter int CICLOS_POR_CM = 2941,
  parameter int DIST_MIN_CM   = 2,
  parameter int DIST_MAX_CM   = 400,
  parameter int TIMEOUT_US    = 38000,
  parameter int ESPERA_US     = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  localparam int TRIG_CICLOS   = TRIG_MIN_US * CICLOS_POR_US;
  localparam int ATRASO_CICLOS = ATRASO_US * CICLOS_POR_US;
  localparam int ESPERA_CICLOS = ESPERA_US * CICLOS_POR_US;

  localparam int CNT_MAX_A = (TRIG_CICLOS > ATRASO_CICLOS) ? TRIG_CICLOS : ATRASO_CICLOS;
  localparam int CNT_MAX   = (CNT_MAX_A > ESPERA_CICLOS) ? CNT_MAX_A : ESPERA_CICLOS;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam int IN_MAX = (CICLOS_POR_CM > CICLOS_POR_US) ? CICLOS_POR_CM : CICLOS_POR_US;
  localparam int IN_W   = $clog2(IN_MAX + 1);

  localparam int OUT_MAX_A = (DIST_MAX_CM > TIMEOUT_US) ? DIST_MAX_CM : TIMEOUT_US;
  localparam int OUT_MAX   = (OUT_MAX_A > DIST_MIN_CM) ? OUT_MAX_A : DIST_MIN_CM;
  localparam int OUT_W     = $clog2(OUT_MAX + 1);

  localparam logic [CNT_W-1:0] TRIG_LIM   = CNT_W'(TRIG_CICLOS);
  localparam logic [CNT_W-1:0] ATRASO_FIM = CNT_W'(ATRASO_CICLOS - 2);
  localparam logic [CNT_W-1:0] ESPERA_FIM = CNT_W'(ESPERA_CICLOS - 1);
  localparam logic [8:0]       DIST_MIN_V = 9'(DIST_MIN_CM);
  localparam logic [8:0]       DIST_MAX_V = 9'(DIST_MAX_CM);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    MEDE_TRIG = 4'd1,
    ATRASO    = 4'd2,
    ECHO      = 4'd3,
    ESPERA    = 4'd4
  } estado_t;

  estado_t          estado_q, estado_d;
  logic             trig_meta_q, trig_meta_d;
  logic             trig_s_q, trig_s_d;
  logic             trig_ant_q, trig_ant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       dist_q, dist_d;
  logic [IN_W-1:0]  inner_q, inner_d;
  logic [IN_W-1:0]  lim_q, lim_d;
  logic [OUT_W-1:0] outer_q, outer_d;
  logic             echo_q, echo_d;
  logic             ocupado_q, ocupado_d;

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned (which would infer a latch).
  always_comb begin
    trig_meta_d = trigger;
    trig_s_d    = trig_meta_q;
    trig_ant_d  = trig_s_q;
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    dist_d      = dist_q;
    inner_d     = inner_q;
    lim_d       = lim_q;
    outer_d     = outer_q;

    case (estado_q)
      INICIAL: begin
        cnt_d = '0;
        // Rising edge only, so a trigger still held high from before is not reused.
        // The detecting cycle is itself a high cycle, hence the count starts at 1.
        if (trig_s_q && !trig_ant_q) begin
          estado_d = MEDE_TRIG;
          cnt_d    = CNT_W'(1);
        end
      end
      MEDE_TRIG: begin
        if (trig_s_q) begin
          if (cnt_q < TRIG_LIM) cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q < TRIG_LIM) begin
          estado_d = INICIAL;
        end else begin
          estado_d = ATRASO;
          dist_d   = distancia;
          cnt_d    = '0;
        end
      end
      ATRASO: begin
        // The falling-edge cycle counts as the first delay cycle.
        if (cnt_q == ATRASO_FIM) begin
          estado_d = ECHO;
          cnt_d    = '0;
          inner_d  = '0;
          if (dist_q > DIST_MAX_V) begin
            lim_d   = IN_W'(CICLOS_POR_US - 1);
            outer_d = OUT_W'(TIMEOUT_US);
          end else if (dist_q < DIST_MIN_V) begin
            lim_d   = IN_W'(CICLOS_POR_CM - 1);
            outer_d = OUT_W'(DIST_MIN_CM);
          end else begin
            lim_d   = IN_W'(CICLOS_POR_CM - 1);
            outer_d = OUT_W'(dist_q);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ECHO: begin
        if (inner_q == lim_q) begin
          inner_d = '0;
          if (outer_q == OUT_W'(1)) estado_d = ESPERA;
          else                      outer_d  = outer_q - OUT_W'(1);
        end else begin
          inner_d = inner_q + IN_W'(1);
        end
      end
      ESPERA: begin
        if (cnt_q == ESPERA_FIM) estado_d = INICIAL;
        else                     cnt_d    = cnt_q + CNT_W'(1);
      end
      default: estado_d = INICIAL;
    endcase

    echo_d    = (estado_d == ECHO);
    ocupado_d = (estado_d == ATRASO) || (estado_d == ECHO) || (estado_d == ESPERA);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= INICIAL;
      trig_meta_q <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_ant_q  <= 1'b0;
      cnt_q       <= '0;
      dist_q      <= '0;
      inner_q     <= '0;
      lim_q       <= '0;
      outer_q     <= '0;
      echo_q      <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      trig_meta_q <= trig_meta_d;
      trig_s_q    <= trig_s_d;
      trig_ant_q  <= trig_ant_d;
      cnt_q       <= cnt_d;
      dist_q      <= dist_d;
      inner_q     <= inner_d;
      lim_q       <= lim_d;
      outer_q     <= outer_d;
      echo_q      <= echo_d;
      ocupado_q   <= ocupado_d;
    end
  end

  assign echo      = echo_q;
  assign ocupado   = ocupado_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_hcsr04_emulador.sv
// Directed bench for hcsr04_emulador with scaled-down timing parameters:
// 2 cycles/us, 20-cycle minimum trigger, 80-cycle delay, 7 cycles/cm, 1000-cycle timeout, 20-cycle hold-off.
module tb_hcsr04_emulador;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic [8:0] distancia = '0;
  logic       echo;
  logic       ocupado;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;

  hcsr04_emulador #(
    .CICLOS_POR_US(2),
    .TRIG_MIN_US  (10),
    .ATRASO_US    (40),
    .CICLOS_POR_CM(7),
    .DIST_MIN_CM  (2),
    .DIST_MAX_CM  (400),
    .TIMEOUT_US   (500),
    .ESPERA_US    (10)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .trigger  (trigger),
    .distancia(distancia),
    .echo     (echo),
    .ocupado  (ocupado),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int n);
    trigger = 1'b1;
    repeat (n) tick();
    trigger = 1'b0;
  endtask

  task automatic idle(input int n, output int echo_hi, output int ocup_hi);
    echo_hi = 0;
    ocup_hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (echo)    echo_hi++;
      if (ocupado) ocup_hi++;
    end
  endtask

  // Fires a 20-cycle trigger and measures delay, echo width and hold-off.
  // retrig_at > 0 pulses the trigger again during the echo; new_dist is
  // applied to distancia inside the delay window.
  task automatic measure(input string tag, input int d, input int exp_w,
                         input int retrig_at, input int new_dist, output int w);
    int k;
    int lat;
    int h;
    distancia = 9'(d);
    pulse(20);
    lat = -1;
    k = 0;
    while (k < 200) begin
      tick();
      k++;
      if (k == 2) check({tag, "_ocup_pre"}, int'(ocupado), 0);
      if (k == 3) check({tag, "_ocup_on"}, int'(ocupado), 1);
      if (k == 5) distancia = 9'(new_dist);
      if (echo) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, 82);
    w = 1;
    while (w < 5000) begin
      tick();
      if (!echo) break;
      w++;
      if (retrig_at > 0 && w == retrig_at)      trigger = 1'b1;
      if (retrig_at > 0 && w == retrig_at + 20) trigger = 1'b0;
    end
    check({tag, "_width"}, w, exp_w);
    h = 0;
    while (h < 200 && ocupado) begin
      tick();
      h++;
    end
    check({tag, "_holdoff"}, h, 20);
    check({tag, "_state_end"}, int'(db_estado), 0);
  endtask

  initial begin
    int w;
    int e_hi;
    int o_hi;
    int n;

    // Reset for 2 us.
    reset = 1'b1;
    repeat (4) tick();
    check("rst_echo", int'(echo), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_estado", int'(db_estado), 0);
    reset = 1'b0;
    repeat (5) tick();

    // 100 cm, with distancia changed during the delay: 100*7 cycles.
    measure("d100", 100, 700, 0, 300, w);
    // 74 cm: 518 cycles; a core dividing by 7 cycles/cm must read 74.
    measure("d74", 74, 518, 0, 74, w);
    check("d74_cm_readback", w / 7, 74);

    // Short trigger (one cycle under the minimum) is ignored.
    distancia = 9'd50;
    pulse(19);
    idle(150, e_hi, o_hi);
    check("short_echo", e_hi, 0);
    check("short_ocupado", o_hi, 0);
    check("short_state", int'(db_estado), 0);

    // Range boundaries.
    measure("d450_timeout", 450, 1000, 0, 450, w);
    measure("d401_timeout", 401, 1000, 0, 401, w);
    measure("d400_max", 400, 2800, 0, 400, w);
    measure("d0_clamp", 0, 14, 0, 0, w);
    measure("d1_clamp", 1, 14, 0, 1, w);
    measure("d2_min", 2, 14, 0, 2, w);

    // Second trigger in mid-echo is ignored: one echo of the original width.
    measure("retrig", 100, 700, 100, 100, w);
    idle(150, e_hi, o_hi);
    check("retrig_no_second_echo", e_hi, 0);
    check("retrig_no_second_busy", o_hi, 0);

    // Trigger raised during hold-off and still high entering INICIAL: no request.
    distancia = 9'd10;
    pulse(20);
    n = 0;
    while (n < 200 && !echo) begin tick(); n++; end
    while (n < 400 && echo)  begin tick(); n++; end
    check("held_reached_espera", int'(db_estado), 4);
    trigger = 1'b1;
    idle(60, e_hi, o_hi);
    check("held_high_state", int'(db_estado), 0);
    check("held_high_ocupado", int'(ocupado), 0);
    trigger = 1'b0;
    idle(150, e_hi, o_hi);
    check("held_no_echo", e_hi, 0);
    check("held_no_busy", o_hi, 0);
    measure("after_held", 20, 140, 0, 20, w);

    // Reset in mid-echo: echo and state clear on the next edge.
    distancia = 9'd50;
    pulse(20);
    n = 0;
    while (n < 200 && !echo) begin tick(); n++; end
    check("rst_mid_echo_started", int'(echo), 1);
    repeat (30) tick();
    check("rst_mid_state_echo", int'(db_estado), 3);
    reset = 1'b1;
    tick();
    check("rst_mid_echo", int'(echo), 0);
    check("rst_mid_estado", int'(db_estado), 0);
    check("rst_mid_ocupado", int'(ocupado), 0);
    reset = 1'b0;
    idle(400, e_hi, o_hi);
    check("rst_mid_no_resume", e_hi, 0);

    // Normal operation after the abort.
    measure("after_rst", 5, 35, 0, 5, w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
